// File: rtl/intr_request_ctrl_pkg.sv
// Shared types and helpers for the RAT interrupt request controller.
// Holds the FSM state encoding, the SRC_ID valid-bit position and the priority encoder.
package rat_intr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } intr_state_t;

   localparam int SRC_ID_VALID_BIT = 7;

   // Lowest set index wins; an all-zero vector encodes as 0.
   function automatic logic [2:0] prio_enc(input logic [7:0] vec);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (vec[i]) idx = i[2:0];
      end
      return idx;
   endfunction

endpackage

// File: rtl/intr_request_ctrl_if.sv
// Source, mask, strobe and status signals between the CPU port decode and the interrupt controller.
// master drives pulses and strobes; slave is the controller side.
interface intr_request_ctrl_if #(
   parameter int N_SRC = 4
);
   logic [N_SRC-1:0] SRC_PULSE;
   logic             MASK_WE;
   logic [7:0]       MASK_DIN;
   logic             INT_ACK;
   logic             EOI;
   logic             INTR;
   logic [7:0]       SRC_ID;
   logic [N_SRC-1:0] PENDING;
   logic [N_SRC-1:0] OVERRUN;

   modport master (
      output SRC_PULSE, MASK_WE, MASK_DIN, INT_ACK, EOI,
      input  INTR, SRC_ID, PENDING, OVERRUN
   );

   modport slave (
      input  SRC_PULSE, MASK_WE, MASK_DIN, INT_ACK, EOI,
      output INTR, SRC_ID, PENDING, OVERRUN
   );
endinterface

// File: rtl/intr_request_ctrl_pulse_edge_detect.sv
// Rising-edge detector: a pulse held for several clocks yields one rise.
// rise is combinational from the current input against its registered copy; no backpressure.
module pulse_edge_detect #(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] pulse,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] src_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) src_q <= '0;
      else     src_q <= pulse;
   end

   assign rise = pulse & ~src_q;

endmodule

// File: rtl/intr_request_ctrl.sv
// Latches source pulses as pending events, masks and arbitrates them, and hands one at a time to the MCU.
// INTR rises one clock after PENDING sets; strobes outside their state are dropped, nothing is back-pressured.
module intr_request_ctrl
   import rat_intr_pkg::*;
#(
   parameter int               N_SRC    = 4,
   parameter logic [N_SRC-1:0] MASK_RST = '0
) (
   input  logic              CLK,
   input  logic              RST,
   intr_request_ctrl_if.slave bus
);

   intr_state_t      state_q, state_d;
   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] pending_q, overrun_q, mask_q;
   logic [N_SRC-1:0] pend_masked, ack_clr;
   logic [2:0]       id_q, ack_idx;
   logic             req, ack_take;
   logic             unused_mask_bits;

   pulse_edge_detect #(.WIDTH(N_SRC)) u_edge (
      .CLK   (CLK),
      .RST   (RST),
      .pulse (bus.SRC_PULSE),
      .rise  (rise)
   );

   assign unused_mask_bits = ^bus.MASK_DIN;
   assign pend_masked      = pending_q & mask_q;
   assign req              = |pend_masked;
   assign ack_take         = (state_q == ST_REQ) && bus.INT_ACK;
   assign ack_idx          = prio_enc(8'(pend_masked));

   always_comb begin
      ack_clr = '0;
      for (int i = 0; i < N_SRC; i++) begin
         ack_clr[i] = ack_take && (ack_idx == 3'(i));
      end
   end

   // A rise on the bit being acknowledged re-arms it and is not an overrun.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pending_q <= '0;
         overrun_q <= '0;
         mask_q    <= MASK_RST;
         id_q      <= 3'd0;
      end else begin
         pending_q <= (pending_q & ~ack_clr) | rise;
         overrun_q <= overrun_q | (rise & pending_q & ~ack_clr);
         if (bus.MASK_WE) mask_q <= bus.MASK_DIN[N_SRC-1:0];
         if (ack_take)    id_q   <= ack_idx;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = ST_IDLE;
      case (state_q)
         ST_IDLE:    state_d = req ? ST_REQ : ST_IDLE;
         ST_REQ: begin
            if (bus.INT_ACK) state_d = ST_SERVICE;
            else if (!req)   state_d = ST_IDLE;
            else             state_d = ST_REQ;
         end
         ST_SERVICE: state_d = bus.EOI ? ST_IDLE : ST_SERVICE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.INTR   = 1'b0;
      bus.SRC_ID = 8'h00;
      case (state_q)
         ST_REQ:     bus.INTR = 1'b1;
         ST_SERVICE: begin
            bus.SRC_ID[SRC_ID_VALID_BIT] = 1'b1;
            bus.SRC_ID[2:0]              = id_q;
         end
         default: ;
      endcase
   end

   assign bus.PENDING = pending_q;
   assign bus.OVERRUN = overrun_q;

endmodule

// File: tb/tb_intr_request_ctrl.sv
// Directed vector bench for intr_request_ctrl with N_SRC=4 and the mask cleared at reset.
module tb_intr_request_ctrl;

   logic CLK;
   logic RST;
   int   n_checks;
   int   n_fail;

   intr_request_ctrl_if #(.N_SRC(4)) bus ();

   intr_request_ctrl #(.N_SRC(4), .MASK_RST(4'h0)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   typedef struct {
      logic [3:0] src;
      logic       we;
      logic [7:0] din;
      logic       ack;
      logic       eoi;
      logic       e_intr;
      logic [7:0] e_id;
      logic [3:0] e_pend;
      logic [3:0] e_ovr;
   } vec_t;

   vec_t vecs[$];

   initial CLK = 1'b0;
   always #10 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic intr, input logic [7:0] id,
                          input logic [3:0] pend, input logic [3:0] ovr);
      chk({tag, " INTR"},    32'(bus.INTR),    32'(intr));
      chk({tag, " SRC_ID"},  32'(bus.SRC_ID),  32'(id));
      chk({tag, " PENDING"}, 32'(bus.PENDING), 32'(pend));
      chk({tag, " OVERRUN"}, 32'(bus.OVERRUN), 32'(ovr));
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      //                 src  we din    ack  eoi   intr id     pend ovr
      // reset-pulse-ack on SRC[2], one event for a 3-clk pulse
      vecs.push_back(vec_t'{4'h0,1'b1,8'h0F,1'b0,1'b0, 1'b0,8'h00,4'h0,4'h0});
      vecs.push_back(vec_t'{4'h4,1'b0,8'h00,1'b0,1'b0, 1'b0,8'h00,4'h4,4'h0});
      vecs.push_back(vec_t'{4'h4,1'b0,8'h00,1'b0,1'b0, 1'b1,8'h00,4'h4,4'h0});
      vecs.push_back(vec_t'{4'h4,1'b0,8'h00,1'b0,1'b0, 1'b1,8'h00,4'h4,4'h0});
      vecs.push_back(vec_t'{4'h0,1'b0,8'h00,1'b1,1'b0, 1'b0,8'h82,4'h0,4'h0});
      vecs.push_back(vec_t'{4'h0,1'b0,8'h00,1'b0,1'b1, 1'b0,8'h00,4'h0,4'h0});
      // SRC[3] and SRC[1] together: priority, then re-request after EOI
      vecs.push_back(vec_t'{4'hA,1'b0,8'h00,1'b0,1'b0, 1'b0,8'h00,4'hA,4'h0});
      vecs.push_back(vec_t'{4'h0,1'b0,8'h00,1'b0,1'b0, 1'b1,8'h00,4'hA,4'h0});
      vecs.push_back(vec_t'{4'h0,1'b0,8'h00,1'b1,1'b0, 1'b0,8'h81,4'h8,4'h0});
      vecs.push_back(vec_t'{4'h0,1'b0,8'h00,1'b0,1'b0, 1'b0,8'h81,4'h8,4'h0});
      vecs.push_back(vec_t'{4'h0,1'b0,8'h00,1'b0,1'b1, 1'b0,8'h00,4'h8,4'h0});
      vecs.push_back(vec_t'{4'h0,1'b0,8'h00,1'b0,1'b0, 1'b1,8'h00,4'h8,4'h0});
      vecs.push_back(vec_t'{4'h0,1'b0,8'h00,1'b1,1'b0, 1'b0,8'h83,4'h0,4'h0});
      vecs.push_back(vec_t'{4'h0,1'b0,8'h00,1'b0,1'b1, 1'b0,8'h00,4'h0,4'h0});
      // masked pending, then enable
      vecs.push_back(vec_t'{4'h0,1'b1,8'h00,1'b0,1'b0, 1'b0,8'h00,4'h0,4'h0});
      vecs.push_back(vec_t'{4'h1,1'b0,8'h00,1'b0,1'b0, 1'b0,8'h00,4'h1,4'h0});
      vecs.push_back(vec_t'{4'h0,1'b0,8'h00,1'b0,1'b0, 1'b0,8'h00,4'h1,4'h0});
      vecs.push_back(vec_t'{4'h0,1'b1,8'h01,1'b0,1'b0, 1'b0,8'h00,4'h1,4'h0});
      vecs.push_back(vec_t'{4'h0,1'b0,8'h00,1'b0,1'b0, 1'b1,8'h00,4'h1,4'h0});
      // mask withdrawal in ST_REQ, ack while idle ignored
      vecs.push_back(vec_t'{4'h0,1'b1,8'h00,1'b0,1'b0, 1'b1,8'h00,4'h1,4'h0});
      vecs.push_back(vec_t'{4'h0,1'b0,8'h00,1'b0,1'b0, 1'b0,8'h00,4'h1,4'h0});
      vecs.push_back(vec_t'{4'h0,1'b0,8'h00,1'b1,1'b0, 1'b0,8'h00,4'h1,4'h0});
      // simultaneous ACK+EOI in each state
      vecs.push_back(vec_t'{4'h0,1'b1,8'h0F,1'b0,1'b0, 1'b0,8'h00,4'h1,4'h0});
      vecs.push_back(vec_t'{4'h0,1'b0,8'h00,1'b1,1'b1, 1'b1,8'h00,4'h1,4'h0});
      vecs.push_back(vec_t'{4'h0,1'b0,8'h00,1'b1,1'b1, 1'b0,8'h80,4'h0,4'h0});
      vecs.push_back(vec_t'{4'h0,1'b0,8'h00,1'b1,1'b1, 1'b0,8'h00,4'h0,4'h0});
      // overrun on SRC[1], rise coinciding with its own ack
      vecs.push_back(vec_t'{4'h2,1'b0,8'h00,1'b0,1'b0, 1'b0,8'h00,4'h2,4'h0});
      vecs.push_back(vec_t'{4'h0,1'b0,8'h00,1'b0,1'b0, 1'b1,8'h00,4'h2,4'h0});
      vecs.push_back(vec_t'{4'h2,1'b0,8'h00,1'b0,1'b0, 1'b1,8'h00,4'h2,4'h2});
      vecs.push_back(vec_t'{4'h0,1'b0,8'h00,1'b0,1'b0, 1'b1,8'h00,4'h2,4'h2});
      vecs.push_back(vec_t'{4'h2,1'b0,8'h00,1'b1,1'b0, 1'b0,8'h81,4'h2,4'h2});
      vecs.push_back(vec_t'{4'h0,1'b0,8'h00,1'b0,1'b1, 1'b0,8'h00,4'h2,4'h2});
      vecs.push_back(vec_t'{4'h0,1'b0,8'h00,1'b0,1'b0, 1'b1,8'h00,4'h2,4'h2});
      vecs.push_back(vec_t'{4'h0,1'b0,8'h00,1'b1,1'b0, 1'b0,8'h81,4'h0,4'h2});
      vecs.push_back(vec_t'{4'h0,1'b0,8'h00,1'b0,1'b1, 1'b0,8'h00,4'h0,4'h2});
      // SRC[3] rise in its ack clock: stays pending, no new overrun
      vecs.push_back(vec_t'{4'h8,1'b0,8'h00,1'b0,1'b0, 1'b0,8'h00,4'h8,4'h2});
      vecs.push_back(vec_t'{4'h0,1'b0,8'h00,1'b0,1'b0, 1'b1,8'h00,4'h8,4'h2});
      vecs.push_back(vec_t'{4'h8,1'b0,8'h00,1'b1,1'b0, 1'b0,8'h83,4'h8,4'h2});
      vecs.push_back(vec_t'{4'h0,1'b0,8'h00,1'b0,1'b1, 1'b0,8'h00,4'h8,4'h2});
      vecs.push_back(vec_t'{4'h0,1'b0,8'h00,1'b0,1'b0, 1'b1,8'h00,4'h8,4'h2});

      RST           = 1'b1;
      bus.SRC_PULSE = 4'h0;
      bus.MASK_WE   = 1'b0;
      bus.MASK_DIN  = 8'h00;
      bus.INT_ACK   = 1'b0;
      bus.EOI       = 1'b0;
      repeat (2) tick();
      chk_all("reset", 1'b0, 8'h00, 4'h0, 4'h0);
      RST = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         bus.SRC_PULSE = vecs[i].src;
         bus.MASK_WE   = vecs[i].we;
         bus.MASK_DIN  = vecs[i].din;
         bus.INT_ACK   = vecs[i].ack;
         bus.EOI       = vecs[i].eoi;
         tick();
         chk_all($sformatf("vec%0d", i), vecs[i].e_intr, vecs[i].e_id,
                 vecs[i].e_pend, vecs[i].e_ovr);
      end

      // Async reset landing mid-cycle while in service with a new event pending
      bus.SRC_PULSE = 4'h0;
      bus.INT_ACK   = 1'b1;
      tick();
      chk_all("svc_enter", 1'b0, 8'h83, 4'h0, 4'h2);
      bus.INT_ACK   = 1'b0;
      bus.SRC_PULSE = 4'h1;
      tick();
      chk_all("svc_accum", 1'b0, 8'h83, 4'h1, 4'h2);
      bus.SRC_PULSE = 4'h0;
      #5;
      RST = 1'b1;
      #1;
      chk_all("mid_rst", 1'b0, 8'h00, 4'h0, 4'h0);
      tick();
      RST = 1'b0;

      // Mask is back to all-disabled: the event pends but raises nothing
      bus.SRC_PULSE = 4'h4;
      tick();
      chk_all("post_rst_pend", 1'b0, 8'h00, 4'h4, 4'h0);
      bus.SRC_PULSE = 4'h0;
      tick();
      chk_all("post_rst_masked", 1'b0, 8'h00, 4'h4, 4'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
